// File: rtl/score_counter.sv
// rtl/score_counter.sv - dinosaur-runner score generator (play FSM, prescaled score, level, milestone; optional macro HISCORE_EN adds hiscore)
module score_counter #(
    parameter int SCORE_W   = 13,
    parameter int TICK_DIV  = 500000,
    parameter int MAX_SCORE = 6399,
    parameter int MILESTONE = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               hit,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state,
    output logic [2:0]         level,
    output logic               milestone
`ifdef HISCORE_EN
    ,
    output logic [SCORE_W-1:0] hiscore
`endif
);

    localparam int LEVEL_STEP = 800;
    localparam int PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MS_W       = (MILESTONE > 1) ? $clog2(MILESTONE) : 1;
    localparam int LVL_W      = $clog2(LEVEL_STEP);

    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]    MS_LAST   = MS_W'(MILESTONE - 1);
    localparam logic [LVL_W-1:0]   LVL_LAST  = LVL_W'(LEVEL_STEP - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } play_state_t;

    play_state_t      play_state;
    logic [PRE_W-1:0] pre_cnt;
    // ms_cnt and lvl_cnt shadow score modulo MILESTONE and modulo 800, so
    // neither output needs a divider on the score bus.
    logic [MS_W-1:0]  ms_cnt;
    logic [LVL_W-1:0] lvl_cnt;
    // Set on the edge the score lands on a milestone value; milestone follows one edge later.
    logic             ms_pend;
    logic             tick;
    logic             can_inc;

    assign tick    = (play_state == ST_RUN) && (pre_cnt == PRE_LAST);
    assign can_inc = (score < SCORE_MAX);
    assign state   = play_state;

    // Play FSM with prescaler, saturating score, level and milestone tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_state <= ST_IDLE;
            pre_cnt    <= '0;
            score      <= '0;
            ms_cnt     <= '0;
            lvl_cnt    <= '0;
            level      <= 3'd0;
            ms_pend    <= 1'b0;
            milestone  <= 1'b0;
`ifdef HISCORE_EN
            hiscore    <= '0;
`endif
        end else begin
            ms_pend   <= 1'b0;
            milestone <= ms_pend;
            case (play_state)
                ST_IDLE, ST_OVER: begin
                    // start beats a simultaneous hit; a restart clears the game
                    if (start) begin
                        play_state <= ST_RUN;
                        pre_cnt    <= '0;
                        score      <= '0;
                        ms_cnt     <= '0;
                        lvl_cnt    <= '0;
                        level      <= 3'd0;
                    end
                end
                ST_RUN: begin
                    if (hit) begin
                        // a tick coinciding with the collision is dropped
                        play_state <= ST_OVER;
                        pre_cnt    <= '0;
`ifdef HISCORE_EN
                        if (score > hiscore) begin
                            hiscore <= score;
                        end
`endif
                    end else begin
                        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                        if (tick && can_inc) begin
                            score   <= score + 1'b1;
                            ms_pend <= (ms_cnt == MS_LAST);
                            ms_cnt  <= (ms_cnt == MS_LAST) ? '0 : ms_cnt + 1'b1;
                            if (lvl_cnt == LVL_LAST) begin
                                lvl_cnt <= '0;
                                if (level != 3'd7) begin
                                    level <= level + 3'd1;
                                end
                            end else begin
                                lvl_cnt <= lvl_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    play_state <= ST_IDLE;
                    pre_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_counter.sv
// tb/tb_score_counter.sv - self-checking bench for score_counter (TICK_DIV=4, MILESTONE=100)
module tb_score_counter;

    localparam int TD   = 4;
    localparam int MS   = 100;
    localparam int MAXS = 6399;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        hit;
    logic [12:0] score;
    logic [1:0]  state;
    logic [2:0]  level;
    logic        milestone;
`ifdef HISCORE_EN
    logic [12:0] hiscore;
`endif

    int total = 0;
    int bad   = 0;

    // reference model: plain game rules
    int m_state;
    int m_score;
    int m_run;
    int m_hi;
    bit m_ms;
    bit m_pend;

    typedef struct {
        bit st;
        bit ht;
        int idle;
        int e_state;
        int e_score;
    } vec_t;

    vec_t vecs[8];

    score_counter #(
        .SCORE_W  (13),
        .TICK_DIV (TD),
        .MAX_SCORE(MAXS),
        .MILESTONE(MS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .hit      (hit),
        .score    (score),
        .state    (state),
        .level    (level),
        .milestone(milestone)
`ifdef HISCORE_EN
        ,
        .hiscore  (hiscore)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_score = 0;
        m_run   = 0;
        m_hi    = 0;
        m_ms    = 1'b0;
        m_pend  = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit h);
        bit inc;
        inc = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_ms = m_pend;
            if (m_state == 1) begin
                if (h) begin
                    m_state = 2;
                    if (m_score > m_hi) m_hi = m_score;
                end else begin
                    m_run++;
                    if (m_run % TD == 0 && m_score < MAXS) begin
                        m_score++;
                        inc = 1'b1;
                    end
                end
            end else if (s) begin
                m_state = 1;
                m_score = 0;
                m_run   = 0;
            end
            m_pend = inc && (m_score % MS == 0) && (m_score != 0);
        end
    endtask

    task automatic compare_all();
        int exp_lvl;
        exp_lvl = (m_score / 800 > 7) ? 7 : m_score / 800;
        check("state", state, m_state);
        check("score", score, m_score);
        check("level", level, exp_lvl);
        check("milestone", milestone, m_ms);
`ifdef HISCORE_EN
        check("hiscore", hiscore, m_hi);
`endif
    endtask

    task automatic cycle(input bit s, input bit h);
        start = s;
        hit   = h;
        @(posedge clk);
        model_edge(s, h);
        @(negedge clk);
        compare_all();
        start = 1'b0;
        hit   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(0, 0);
        cycle(0, 0);
        check("rst_state", state, 0);
        check("rst_score", score, 0);
        rst_n = 1'b1;
    endtask

    task automatic run_until(input int target, input int bound);
        int n;
        n = 0;
        while (m_score != target && n < bound) begin
            cycle(0, 0);
            n++;
        end
        check("reach_score", score, target);
    endtask

    initial begin
        int seen;

        vecs[0] = '{st: 1'b0, ht: 1'b1, idle: 3, e_state: 0, e_score: 0};
        vecs[1] = '{st: 1'b1, ht: 1'b1, idle: 0, e_state: 1, e_score: 0};
        vecs[2] = '{st: 1'b0, ht: 1'b0, idle: 3, e_state: 1, e_score: 1};
        vecs[3] = '{st: 1'b1, ht: 1'b0, idle: 3, e_state: 1, e_score: 2};
        vecs[4] = '{st: 1'b0, ht: 1'b1, idle: 5, e_state: 2, e_score: 2};
        vecs[5] = '{st: 1'b0, ht: 1'b1, idle: 2, e_state: 2, e_score: 2};
        vecs[6] = '{st: 1'b1, ht: 1'b1, idle: 0, e_state: 1, e_score: 0};
        vecs[7] = '{st: 1'b0, ht: 1'b0, idle: 7, e_state: 1, e_score: 2};

        rst_n = 1'b0;
        start = 1'b0;
        hit   = 1'b0;
        model_reset();

        // idle after reset: nothing moves, no milestone
        do_reset();
        check("rst_level", level, 0);
        check("rst_milestone", milestone, 0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(0, 0);
            if (milestone === 1'b1) seen++;
        end
        check("idle_state", state, 0);
        check("idle_score", score, 0);
        check("idle_ms_count", seen, 0);

        // table of short start/hit sequences
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].st, vecs[i].ht);
            for (int k = 0; k < vecs[i].idle; k++) cycle(0, 0);
            check($sformatf("vec%0d_state", i), state, vecs[i].e_state);
            check($sformatf("vec%0d_score", i), score, vecs[i].e_score);
        end

        // start at cycle 10, increments at 14 and 18, then hit freezes
        do_reset();
        for (int i = 1; i <= 9; i++) cycle(0, 0);
        cycle(1, 0);
        check("t2_state_run", state, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0);
        check("t2_score_c13", score, 0);
        cycle(0, 0);
        check("t2_score_c14", score, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0);
        check("t2_score_c18", score, 2);
        cycle(0, 1);
        check("t2_state_over", state, 2);
        for (int i = 0; i < 6; i++) cycle(0, 0);
        check("t2_score_frozen", score, 2);

        // milestone at 100, level step at 800
        cycle(1, 0);
        check("t3_restart_score", score, 0);
        run_until(100, 1000);
        check("t3_ms_same_cycle", milestone, 0);
        check("t3_level_100", level, 0);
        cycle(0, 0);
        check("t3_ms_next_cycle", milestone, 1);
        cycle(0, 0);
        check("t3_ms_pulse_end", milestone, 0);
        run_until(799, 4000);
        check("t3_level_799", level, 0);
        run_until(800, 100);
        check("t3_level_800", level, 1);

        // hit coinciding with tick at 37, then restart from OVER
        cycle(0, 1);
        cycle(1, 0);
        run_until(37, 1000);
        for (int i = 0; i < 3; i++) cycle(0, 0);
        cycle(0, 1);
        check("t4_score_37", score, 37);
        check("t4_state_over", state, 2);
        cycle(1, 0);
        check("t4_restart_score", score, 0);
        check("t4_restart_state", state, 1);

        // saturation at MAX_SCORE
        run_until(MAXS, 30000);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0);
            if (milestone === 1'b1) seen++;
        end
        check("t5_sat_score", score, MAXS);
        check("t5_sat_level", level, 7);
        check("t5_sat_ms_count", seen, 0);

        // asynchronous reset mid-RUN clears outputs without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_score", score, 0);
        check("arst_level", level, 0);
        check("arst_milestone", milestone, 0);
`ifdef HISCORE_EN
        check("arst_hiscore", hiscore, 0);
`endif
        model_reset();
        cycle(0, 0);
        rst_n = 1'b1;

        // games ending at 50, 20, 70
        cycle(1, 0);
        run_until(50, 1000);
        cycle(0, 1);
`ifdef HISCORE_EN
        check("hi_after_50", hiscore, 50);
`endif
        cycle(1, 0);
        run_until(20, 1000);
        cycle(0, 1);
`ifdef HISCORE_EN
        check("hi_after_20", hiscore, 50);
`endif
        cycle(1, 0);
        run_until(70, 1000);
        cycle(0, 1);
`ifdef HISCORE_EN
        check("hi_after_70", hiscore, 70);
`endif
        check("games_state_over", state, 2);

        // randomized start/hit traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
